// File: rtl/demux2_buf_pkg.sv
// Shared constants for demux2_buf: channel select encodings and default datapath width.
// Optional bypass path is controlled by the DEMUX2_BUF_BYPASS_EN macro in chan_buf.
package demux2_buf_pkg;

  localparam logic SEL_CH0   = 1'b0;
  localparam logic SEL_CH1   = 1'b1;
  localparam int   NBITS_DEF = 4;

endpackage

// File: rtl/demux2_buf_chan_buf.sv
// One-entry valid/ready pipeline register for a single demux output channel.
// With DEMUX2_BUF_BYPASS_EN defined, an enqueue into an empty, ready channel passes straight through.
module chan_buf
  import demux2_buf_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [NBITS-1:0] enq_data,
  input  logic             out_rdy,
  output logic             full,
  output logic             out_val,
  output logic [NBITS-1:0] out_data
);

  logic             full_q, full_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             wr_en;
`ifdef DEMUX2_BUF_BYPASS_EN
  logic             bypass;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
`ifdef DEMUX2_BUF_BYPASS_EN
    bypass   = enq && !full_q && out_rdy;
    wr_en    = enq && !bypass;
    out_val  = full_q || bypass;
    out_data = bypass ? enq_data : data_q;
`else
    wr_en    = enq;
    out_val  = full_q;
    out_data = data_q;
`endif
    // An enqueue wins over a same-cycle dequeue: the entry stays full with the new payload.
    if (wr_en) begin
      full_d = 1'b1;
      data_d = enq_data;
    end else if (full_q && out_rdy) begin
      full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the data register is cleared on reset too, keeping out_data deterministic from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;

endmodule

// File: rtl/demux2_buf.sv
// 1:2 valid/ready demux with a one-entry buffer per output channel; in_rdy only looks at the selected channel.
// Define DEMUX2_BUF_BYPASS_EN for zero-latency pass-through into empty, ready channels.
module demux2_buf
  import demux2_buf_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_sel,
  input  logic [NBITS-1:0] in_data,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [NBITS-1:0] out0_data,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [NBITS-1:0] out1_data
);

  logic full0, full1;
  logic enq0, enq1;
  logic sel_full, sel_rdy;

  always_comb begin
    sel_full = (in_sel == SEL_CH1) ? full1 : full0;
    sel_rdy  = (in_sel == SEL_CH1) ? out1_rdy : out0_rdy;
    // A full buffer that drains this cycle can take the next word.
    in_rdy   = !sel_full || sel_rdy;
    enq0     = in_val && in_rdy && (in_sel == SEL_CH0) && !rst;
    enq1     = in_val && in_rdy && (in_sel == SEL_CH1) && !rst;
  end

  chan_buf #(.NBITS(NBITS)) u_chan0 (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq0),
    .enq_data (in_data),
    .out_rdy  (out0_rdy),
    .full     (full0),
    .out_val  (out0_val),
    .out_data (out0_data)
  );

  chan_buf #(.NBITS(NBITS)) u_chan1 (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq1),
    .enq_data (in_data),
    .out_rdy  (out1_rdy),
    .full     (full1),
    .out_val  (out1_val),
    .out_data (out1_data)
  );

endmodule

// File: tb/tb_demux2_buf.sv
// Directed, table-driven bench for demux2_buf; each row is applied for one cycle and checked around the edge.
module tb_demux2_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val;
  logic       in_rdy;
  logic       in_sel;
  logic [3:0] in_data;
  logic       out0_val;
  logic       out0_rdy;
  logic [3:0] out0_data;
  logic       out1_val;
  logic       out1_rdy;
  logic [3:0] out1_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux2_buf #(.NBITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out0_val  (out0_val),
    .out0_rdy  (out0_rdy),
    .out0_data (out0_data),
    .out1_val  (out1_val),
    .out1_rdy  (out1_rdy),
    .out1_data (out1_data)
  );

  typedef struct {
    logic       rst;
    logic       val;
    logic       sel;
    logic [3:0] data;
    logic       r0;
    logic       r1;
    logic       chk_rdy;
    logic       e_rdy;
    logic       e_v0;
    logic [3:0] e_d0;
    logic       e_v1;
    logic [3:0] e_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic s, logic [3:0] d, logic r0, logic r1,
                              logic cr, logic er, logic ev0, logic [3:0] ed0,
                              logic ev1, logic [3:0] ed1);
    vec_t t;
    t.rst = r; t.val = v; t.sel = s; t.data = d; t.r0 = r0; t.r1 = r1;
    t.chk_rdy = cr; t.e_rdy = er; t.e_v0 = ev0; t.e_d0 = ed0; t.e_v1 = ev1; t.e_d1 = ed1;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [3:0] d,
                       input logic r0, input logic r1);
    rst = r; in_val = v; in_sel = s; in_data = d; out0_rdy = r0; out1_rdy = r1;
  endtask

  initial begin
    //           rst val sel data r0 r1  chk rdy  v0 d0    v1 d1
    // Reset held two cycles with in_val=1: nothing enqueues.
    vecs.push_back(mk(1, 1, 0, 4'hF, 0, 0, 0, 1, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk(1, 1, 1, 4'hF, 0, 0, 1, 1, 0, 4'h0, 0, 4'h0));
`ifndef DEMUX2_BUF_BYPASS_EN
    // Steer to channel 0.
    vecs.push_back(mk(0, 1, 0, 4'hA, 1, 1, 1, 1, 1, 4'hA, 0, 4'h0));
    // Stream 1..4 into channel 1 while channel 0 drains.
    vecs.push_back(mk(0, 1, 1, 4'h1, 1, 1, 1, 1, 0, 4'hA, 1, 4'h1));
    vecs.push_back(mk(0, 1, 1, 4'h2, 1, 1, 1, 1, 0, 4'hA, 1, 4'h2));
    vecs.push_back(mk(0, 1, 1, 4'h3, 1, 1, 1, 1, 0, 4'hA, 1, 4'h3));
    vecs.push_back(mk(0, 1, 1, 4'h4, 1, 1, 1, 1, 0, 4'hA, 1, 4'h4));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1, 1, 1, 1, 0, 4'hA, 0, 4'h4));
    // Isolation: channel 0 stalls, channel 1 keeps flowing.
    vecs.push_back(mk(0, 1, 0, 4'h5, 0, 1, 1, 1, 1, 4'h5, 0, 4'h4));
    vecs.push_back(mk(0, 1, 0, 4'h6, 0, 1, 1, 0, 1, 4'h5, 0, 4'h4));
    vecs.push_back(mk(0, 1, 1, 4'h9, 0, 1, 1, 1, 1, 4'h5, 1, 4'h9));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 4'h5, 0, 4'h9));
    // Full buffer with a simultaneous drain accepts new data.
    vecs.push_back(mk(0, 1, 0, 4'h3, 1, 0, 1, 1, 1, 4'h3, 0, 4'h9));
    vecs.push_back(mk(0, 1, 0, 4'h7, 1, 0, 1, 1, 1, 4'h7, 0, 4'h9));
    // in_val=0: sel/data ignored, state held.
    vecs.push_back(mk(0, 0, 1, 4'hF, 0, 0, 1, 1, 1, 4'h7, 0, 4'h9));
    // Fill both channels with C and D, then reset mid-flight.
    vecs.push_back(mk(0, 1, 0, 4'hC, 1, 0, 1, 1, 1, 4'hC, 0, 4'h9));
    vecs.push_back(mk(0, 1, 1, 4'hD, 0, 0, 1, 1, 1, 4'hC, 1, 4'hD));
    vecs.push_back(mk(1, 1, 0, 4'hE, 1, 1, 1, 1, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h0, 0, 4'h0));
`endif

    drive(1, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].val, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
      #1;
      if (vecs[i].chk_rdy) check($sformatf("in_rdy[%0d]", i), 32'(in_rdy), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("out0_val[%0d]", i),  32'(out0_val),  32'(vecs[i].e_v0));
      check($sformatf("out0_data[%0d]", i), 32'(out0_data), 32'(vecs[i].e_d0));
      check($sformatf("out1_val[%0d]", i),  32'(out1_val),  32'(vecs[i].e_v1));
      check($sformatf("out1_data[%0d]", i), 32'(out1_data), 32'(vecs[i].e_d1));
    end

`ifdef DEMUX2_BUF_BYPASS_EN
    // Empty and ready channel 0: E appears in the same cycle and the buffer stays empty.
    drive(0, 1, 0, 4'hE, 1, 1);
    #1;
    check("byp in_rdy",    32'(in_rdy),    32'd1);
    check("byp out0_val",  32'(out0_val),  32'd1);
    check("byp out0_data", 32'(out0_data), 32'hE);
    check("byp out1_val",  32'(out1_val),  32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'h0, 1, 1);
    #1;
    check("byp no_write", 32'(out0_val), 32'd0);
    // Not ready: no bypass, data lands in the buffer one cycle later.
    drive(0, 1, 1, 4'h5, 0, 0);
    #1;
    check("byp stall same", 32'(out1_val), 32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'h0, 0, 0);
    #1;
    check("byp stall val",  32'(out1_val),  32'd1);
    check("byp stall data", 32'(out1_data), 32'h5);
    // Full channel with drain still goes through the buffer.
    drive(0, 1, 1, 4'h6, 0, 1);
    #1;
    check("byp full data", 32'(out1_data), 32'h5);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'h0, 0, 0);
    #1;
    check("byp full next", 32'(out1_data), 32'h6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
